// File: rtl/seg_load_if.sv
// Load handshake between the app logic and the display scan controller:
// six hex digits plus per-digit decimal points, transferred on valid & ready.
interface seg_load_if;
    logic        load_valid;
    logic        load_ready;
    logic [23:0] load_data;
    logic [5:0]  load_dp;

    modport master (output load_valid, load_data, load_dp, input load_ready);
    modport slave  (input load_valid, load_data, load_dp, output load_ready);
endinterface

// File: rtl/seg_scan_ctrl.sv
// Six-digit 7-segment scan scheduler with frame-synchronous value commit.
// Optional macro SEG_BLANK_LEAD_ZERO_EN blanks leading-zero digits 5..1.
module seg_scan_ctrl #(
    parameter int unsigned DIGIT_CNT = 50000,
    parameter int unsigned CNT_W     = 16
) (
    input  logic          sys_clk,
    input  logic          rst,
    input  logic          en,
    seg_load_if.slave     load,
    output logic          frame_done,
    output logic [5:0]    sel,
    output logic [7:0]    seg
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIGIT_CNT - 1);
    localparam logic [2:0]       IDX_MAX = 3'd5;

    typedef enum logic {OFF, SCAN} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [2:0]       idx, idx_nx;
    logic             frame_end_c;

    logic [23:0] act_data, pend_data;
    logic [5:0]  act_dp, pend_dp;
    logic        pending;
    logic        xfer_c, commit_c, pending_nx_c;

    logic [3:0]  nib_c;
    logic        dp_c;
    logic        blank_c;
    logic [6:0]  segs_c;

    // Active-low a..g pattern for one hex nibble
    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0:    hex7 = 7'h40;
            4'h1:    hex7 = 7'h79;
            4'h2:    hex7 = 7'h24;
            4'h3:    hex7 = 7'h30;
            4'h4:    hex7 = 7'h19;
            4'h5:    hex7 = 7'h12;
            4'h6:    hex7 = 7'h02;
            4'h7:    hex7 = 7'h78;
            4'h8:    hex7 = 7'h00;
            4'h9:    hex7 = 7'h10;
            4'hA:    hex7 = 7'h08;
            4'hB:    hex7 = 7'h03;
            4'hC:    hex7 = 7'h46;
            4'hD:    hex7 = 7'h21;
            4'hE:    hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state <= OFF;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            idx   <= idx_nx;
        end
    end

    // Dwell counter and digit index advance; both clear whenever the display is off
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        idx_nx      = idx;
        frame_end_c = 1'b0;
        case (state)
            OFF: begin
                cnt_nx = '0;
                idx_nx = '0;
                if (en) state_nx = SCAN;
            end
            SCAN: begin
                if (!en) begin
                    state_nx = OFF;
                    cnt_nx   = '0;
                    idx_nx   = '0;
                end else if (cnt == CNT_MAX) begin
                    cnt_nx      = '0;
                    idx_nx      = (idx == IDX_MAX) ? 3'd0 : idx + 3'd1;
                    frame_end_c = (idx == IDX_MAX);
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: state_nx = OFF;
        endcase
    end

    // A dark display commits at once so the loader never stalls
    assign xfer_c       = load.load_valid & load.load_ready;
    assign commit_c     = pending & (frame_end_c | (state == OFF));
    assign pending_nx_c = xfer_c | (pending & ~commit_c);

`ifdef SEG_BLANK_LEAD_ZERO_EN
    logic [5:0] lz_c;

    // lz_c[i]: nibbles i..5 are all zero; digit 0 always shows
    always_comb begin
        lz_c    = '0;
        lz_c[5] = (act_data[23:20] == 4'h0);
        for (int i = 4; i >= 1; i--) begin
            lz_c[i] = lz_c[i+1] & (act_data[4*i +: 4] == 4'h0);
        end
    end
`endif

    always_comb begin
        nib_c   = act_data[3:0];
        dp_c    = act_dp[0];
        blank_c = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (idx == 3'(i)) begin
                nib_c = act_data[4*i +: 4];
                dp_c  = act_dp[i];
`ifdef SEG_BLANK_LEAD_ZERO_EN
                blank_c = lz_c[i];
`endif
            end
        end
        segs_c = blank_c ? 7'h7F : hex7(nib_c);
    end

    // Old pending value moves to active before a same-edge transfer overwrites it
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            act_data        <= '0;
            act_dp          <= '0;
            pend_data       <= '0;
            pend_dp         <= '0;
            pending         <= 1'b0;
            load.load_ready <= 1'b1;
            frame_done      <= 1'b0;
            sel             <= 6'h3F;
            seg             <= 8'hFF;
        end else begin
            if (commit_c) begin
                act_data <= pend_data;
                act_dp   <= pend_dp;
            end
            if (xfer_c) begin
                pend_data <= load.load_data;
                pend_dp   <= load.load_dp;
            end
            pending         <= pending_nx_c;
            load.load_ready <= ~pending_nx_c;
            frame_done      <= frame_end_c;
            sel             <= (state == SCAN) ? ~(6'(1) << idx) : 6'h3F;
            seg             <= (state == SCAN) ? {~dp_c, segs_c} : 8'hFF;
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: expected digit/segment/dwell entries are
// queued by the stimulus and popped by a monitor on every display change.
module tb_seg_scan_ctrl;
    localparam int unsigned DC = 4;

    logic       sys_clk = 1'b0;
    logic       rst;
    logic       en;
    logic       frame_done;
    logic [5:0] sel;
    logic [7:0] seg;

    seg_load_if ld();

    seg_scan_ctrl #(.DIGIT_CNT(DC), .CNT_W(16)) dut (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .en        (en),
        .load      (ld),
        .frame_done(frame_done),
        .sel       (sel),
        .seg       (seg)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [5:0] sel;
        logic [7:0] seg;
        logic [7:0] len;   // expected dwell in samples, 0 = don't care
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    localparam logic [5:0] SELS [6] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};

    // Per-frame segment patterns, digit 5 in the top byte
    localparam logic [47:0] F_543210 = {8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};
`ifdef SEG_BLANK_LEAD_ZERO_EN
    localparam logic [47:0] F_ZERO   = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0};
    localparam logic [47:0] F_120    = {8'hFF, 8'hFF, 8'hFF, 8'hF9, 8'hA4, 8'hC0};
`else
    localparam logic [47:0] F_ZERO   = {8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
    localparam logic [47:0] F_120    = {8'hC0, 8'hC0, 8'hC0, 8'hF9, 8'hA4, 8'hC0};
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [5:0] s, input logic [7:0] g, input logic [7:0] l);
        exp_q.push_back('{sel: s, seg: g, len: l});
    endtask

    task automatic push_frame(input logic [47:0] f);
        for (int i = 0; i < 6; i++) push(SELS[i], f[8*i +: 8], 8'd4);
    endtask

    task automatic wait_sel(input logic [5:0] v);
        int n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (sel !== v && n < 200);
        if (sel !== v) chk("wait_sel_timeout", 32'(sel), 32'(v));
    endtask

    task automatic wait_fd(output int n);
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (frame_done !== 1'b1 && n < 200);
        if (frame_done !== 1'b1) chk("wait_fd_timeout", 32'(frame_done), 32'd1);
    endtask

    // Monitor: every change of {sel,seg} must match the queue head, and the
    // previous entry must have lasted exactly its expected number of samples
    logic [13:0] prev_v = 14'bx;
    exp_t        cur;
    logic        have_cur = 1'b0;
    int          run = 0;

    always @(negedge sys_clk) begin
        if ({sel, seg} !== prev_v) begin
            if (have_cur && cur.len != 8'd0) chk("dwell_len", 32'(run), 32'(cur.len));
            if (exp_q.size() == 0) begin
                chk("unexpected_change", {18'd0, sel, seg}, 32'd0);
                have_cur = 1'b0;
            end else begin
                cur = exp_q.pop_front();
                have_cur = 1'b1;
                chk("sel_seg", {18'd0, sel, seg}, {18'd0, cur.sel, cur.seg});
            end
            run    = 1;
            prev_v = {sel, seg};
        end else begin
            run++;
        end
    end

    initial begin
        int n;
        int bad;
        rst = 1'b1;
        en  = 1'b0;
        ld.load_valid = 1'b0;
        ld.load_data  = '0;
        ld.load_dp    = '0;
        push(6'h3F, 8'hFF, 8'd0);

        repeat (2) @(negedge sys_clk);
        chk("rst_ready", 32'(ld.load_ready), 32'd1);
        chk("rst_fd", 32'(frame_done), 32'd0);
        #1 rst = 1'b0;

        // Dark display holds idle outputs
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge sys_clk);
            if (ld.load_ready !== 1'b1 || frame_done !== 1'b0) bad++;
        end
        chk("idle_50", 32'(bad), 32'd0);

        // Load while off: accepted and committed on the next edge
        #1 begin ld.load_valid = 1'b1; ld.load_data = 24'h543210; ld.load_dp = 6'h00; end
        @(negedge sys_clk);
        chk("off_xfer_ready", 32'(ld.load_ready), 32'd0);
        #1 ld.load_valid = 1'b0;
        @(negedge sys_clk);
        chk("off_commit_ready", 32'(ld.load_ready), 32'd1);

        push_frame(F_543210);
        push_frame(F_543210);
        #1 en = 1'b1;
        wait_fd(n);
        @(negedge sys_clk);
        chk("fd_pulse_width", 32'(frame_done), 32'd0);
        push_frame(F_543210);
        wait_fd(n);
        chk("fd_period", 32'(n + 1), 32'd24);

        // Mid-frame load: current frame unchanged, ready low until commit
        wait_sel(6'h3B);
        for (int i = 0; i < 3; i++) push(SELS[i], 8'h0E, 8'd4);
        push(6'h37, 8'h0E, 8'd2);
        push(6'h3F, 8'hFF, 8'd0);
        #1 begin ld.load_valid = 1'b1; ld.load_data = 24'hFFFFFF; ld.load_dp = 6'h3F; end
        @(negedge sys_clk);
        chk("mid_xfer_ready", 32'(ld.load_ready), 32'd0);
        #1 ld.load_valid = 1'b0;
        bad = 0;
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
            if (frame_done !== 1'b1 && ld.load_ready !== 1'b0) bad++;
        end while (frame_done !== 1'b1 && n < 100);
        chk("ready_low_until_commit", 32'(bad), 32'd0);
        chk("commit_fd", 32'(frame_done), 32'd1);
        chk("ready_after_commit", 32'(ld.load_ready), 32'd1);

        // Drop enable during digit 3, then restart at digit 0
        wait_sel(6'h37);
        #1 en = 1'b0;
        repeat (6) @(negedge sys_clk);
        chk("off_ready", 32'(ld.load_ready), 32'd1);
        for (int i = 0; i < 4; i++) push(SELS[i], 8'h0E, 8'd4);
        push(6'h2F, 8'h0E, 8'd1);
        push(6'h3F, 8'hFF, 8'd0);
        #1 en = 1'b1;

        // Pending value, then async reset during digit 4
        wait_sel(6'h3B);
        #1 begin ld.load_valid = 1'b1; ld.load_data = 24'h000120; ld.load_dp = 6'h00; end
        @(negedge sys_clk);
        chk("pend_xfer_ready", 32'(ld.load_ready), 32'd0);
        #1 ld.load_valid = 1'b0;
        wait_sel(6'h2F);
        #1 begin rst = 1'b1; en = 1'b0; end
        @(negedge sys_clk);
        chk("mid_rst_ready", 32'(ld.load_ready), 32'd1);
        chk("mid_rst_fd", 32'(frame_done), 32'd0);
        #1 rst = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("post_rst_ready", 32'(ld.load_ready), 32'd1);

        // Active regs are zero and the lost pending value never appears
        push_frame(F_ZERO);
        push_frame(F_ZERO);
        #1 en = 1'b1;
        wait_fd(n);
        wait_sel(6'h3B);
        push_frame(F_120);
        push(6'h3E, 8'hC0, 8'd1);
        push(6'h3F, 8'hFF, 8'd0);
        #1 begin ld.load_valid = 1'b1; ld.load_data = 24'h000120; ld.load_dp = 6'h00; end
        @(negedge sys_clk);
        chk("lz_xfer_ready", 32'(ld.load_ready), 32'd0);
        #1 ld.load_valid = 1'b0;
        wait_fd(n);
        wait_fd(n);
        #1 en = 1'b0;
        repeat (5) @(negedge sys_clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
